// File: rtl/main_memory_model_if.sv
// L2 <-> main-memory request/response bundle. The L2 side uses the master modport
// and the memory side uses the slave modport.
interface main_memory_model_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 1
);
   logic              mem_req_valid;
   logic              mem_req_rw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_data;
   logic              mem_req_ready;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/main_memory_model.sv
// Line-granular main memory responder with fixed read/write latency, one request in flight.
// Define MEM_STATS_EN to add saturating accepted-read/accepted-write counters (rd_count/wr_count).
module main_memory_model #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 1,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   main_memory_model_if.slave   bus
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;

   localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_buf;
   logic              accept;

   // Ready depends on state alone, so the requester may derive valid from it freely.
   assign bus.mem_req_ready = (state == IDLE);
   assign accept            = bus.mem_req_valid && bus.mem_req_ready;

   // Storage is never cleared; reads of unwritten lines return whatever the array holds.
   always_ff @(posedge clk) begin
      if (accept && bus.mem_req_rw && !reset) begin
         mem[bus.mem_req_addr] <= bus.mem_req_data;
      end
      if (accept && !bus.mem_req_rw) begin
         rd_buf <= mem[bus.mem_req_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= '0;
         bus.mem_resp_valid <= 1'b0;
         bus.mem_resp_data  <= '0;
      end else begin
         bus.mem_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!bus.mem_req_rw) begin
                     if (READ_LAT == 1) begin
                        bus.mem_resp_valid <= 1'b1;
                        bus.mem_resp_data  <= mem[bus.mem_req_addr];
                     end else begin
                        state <= RD_WAIT;
                        cnt   <= CNT_W'(READ_LAT - 1);
                     end
                  end else if (WRITE_LAT > 1) begin
                     state <= WR_WAIT;
                     cnt   <= CNT_W'(WRITE_LAT - 1);
                  end
               end
            end
            RD_WAIT: begin
               // Counter reaching one means the response goes out on this edge.
               if (cnt == CNT_W'(1)) begin
                  bus.mem_resp_valid <= 1'b1;
                  bus.mem_resp_data  <= rd_buf;
                  state              <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            WR_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (accept) begin
         if (!bus.mem_req_rw && rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
         end
         if (bus.mem_req_rw && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`endif

endmodule
